note_spawner: RTL and testbench

- Sits directly downstream of the level-select stage and consumes its one-hot `level` and `end_signal`.
- Converts the chosen difficulty into a note budget (8/12/16) and a spawn period (base, /2, /4).
- Emits that many note-spawn requests, each carrying a pseudo-random lane, to the note/display pipeline over a valid/ready handshake.
- Reports `done` to the game manager when the budget is exhausted.

---
 rtl/note_spawner.sv | 141 ++++++++++++++
 tb/tb_note_spawner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/note_spawner.sv
// note_spawner: turns a latched difficulty into a paced burst of note-spawn
// requests with pseudo-random lanes over a valid/ready handshake.
module note_spawner #(
   parameter int         BASE_PERIOD = 64,
   parameter int         TIMER_W     = 24,
   parameter int         N_LOW       = 8,
   parameter int         N_MID       = 12,
   parameter int         N_HIGH      = 16,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] level,
   input  logic       level_valid,
   input  logic       spawn_ready,
   output logic       spawn_valid,
   output logic [1:0] spawn_lane,
   output logic [4:0] notes_left,
   output logic [2:0] speed,
   output logic       busy,
   output logic       done,
   output logic       level_err
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_ACK, S_DONE} state_t;

   localparam logic [TIMER_W-1:0] P_LOW  = TIMER_W'(BASE_PERIOD);
   localparam logic [TIMER_W-1:0] P_MID  = TIMER_W'(BASE_PERIOD / 2);
   localparam logic [TIMER_W-1:0] P_HIGH = TIMER_W'(BASE_PERIOD / 4);
   localparam logic [TIMER_W-1:0] ONE    = TIMER_W'(1);

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d, period_q, period_d;
   logic [7:0]         lfsr_q, lfsr_d;
   logic               spawn_valid_q, spawn_valid_d;
   logic [1:0]         spawn_lane_q, spawn_lane_d;
   logic [4:0]         notes_left_q, notes_left_d;
   logic [2:0]         speed_q, speed_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               level_err_q, level_err_d;
   logic               legal;
   logic [4:0]         n_sel;
   logic [TIMER_W-1:0] p_sel;

   always_comb begin
      lfsr_d        = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      legal         = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);
      n_sel         = level[2] ? 5'(N_HIGH) : level[1] ? 5'(N_MID) : 5'(N_LOW);
      p_sel         = level[2] ? P_HIGH : level[1] ? P_MID : P_LOW;
      state_d       = state_q;
      timer_d       = timer_q;
      period_d      = period_q;
      spawn_valid_d = spawn_valid_q;
      spawn_lane_d  = spawn_lane_q;
      notes_left_d  = notes_left_q;
      speed_d       = speed_q;
      done_d        = done_q;
      level_err_d   = level_err_q;
      case (state_q)
         S_IDLE: begin
            if (level_valid && legal) begin
               state_d      = S_RUN;
               notes_left_d = n_sel;
               period_d     = p_sel;
               timer_d      = p_sel - ONE;
               speed_d      = level;
               level_err_d  = 1'b0;
            end else if (level_valid) begin
               level_err_d  = 1'b1;
            end
         end
         S_RUN, S_WAIT_ACK: begin
            // a dropped level_valid is a player restart and wins over any handshake
            if (!level_valid) begin
               state_d       = S_IDLE;
               spawn_valid_d = 1'b0;
               notes_left_d  = 5'd0;
               speed_d       = 3'd0;
            end else if (state_q == S_RUN) begin
               timer_d = timer_q - ONE;
               if (timer_q == '0) begin
                  state_d       = S_WAIT_ACK;
                  spawn_valid_d = 1'b1;
                  spawn_lane_d  = lfsr_q[1:0];
                  timer_d       = timer_q;
               end
            end else if (spawn_ready) begin
               spawn_valid_d = 1'b0;
               notes_left_d  = notes_left_q - 5'd1;
               state_d       = (notes_left_q == 5'd1) ? S_DONE : S_RUN;
               done_d        = (notes_left_q == 5'd1);
               timer_d       = period_q - ONE;
            end
         end
         default: begin
            if (!level_valid) begin
               state_d = S_IDLE;
               done_d  = 1'b0;
               speed_d = 3'd0;
            end
         end
      endcase
      busy_d = (state_d == S_RUN) || (state_d == S_WAIT_ACK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         period_q      <= '0;
         lfsr_q        <= LFSR_SEED;
         spawn_valid_q <= 1'b0;
         spawn_lane_q  <= 2'd0;
         notes_left_q  <= 5'd0;
         speed_q       <= 3'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         level_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         period_q      <= period_d;
         lfsr_q        <= lfsr_d;
         spawn_valid_q <= spawn_valid_d;
         spawn_lane_q  <= spawn_lane_d;
         notes_left_q  <= notes_left_d;
         speed_q       <= speed_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         level_err_q   <= level_err_d;
      end
   end

   assign spawn_valid = spawn_valid_q;
   assign spawn_lane  = spawn_lane_q;
   assign notes_left  = notes_left_q;
   assign speed       = speed_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign level_err   = level_err_q;
endmodule

// File: tb/tb_note_spawner.sv
// tb_note_spawner: directed rounds plus random traffic, every cycle compared
// against an edge-timeline model of the spawner.
module tb_note_spawner;
   localparam int BASE = 64;

   logic       clk = 1'b0;
   logic       rst, level_valid, spawn_ready;
   logic [2:0] level;
   logic       spawn_valid, busy, done, level_err;
   logic [1:0] spawn_lane;
   logic [4:0] notes_left;
   logic [2:0] speed;

   int total = 0;
   int bad   = 0;

   note_spawner dut (
      .clk(clk), .rst(rst), .level(level), .level_valid(level_valid),
      .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
      .notes_left(notes_left), .speed(speed), .busy(busy), .done(done),
      .level_err(level_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // lane reference: LFSR value held during the k-th edge after reset
   logic [7:0] seq [16384];
   initial begin
      logic [7:0] l;
      l = 8'hA5;
      for (int i = 0; i < 16384; i++) begin
         seq[i] = l;
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
   end

   // model: round as a timeline of absolute edge numbers
   int   steps, ecount, next_edge;
   bit   m_act, m_pend, m_done, m_err;
   int   m_lane, m_left, m_speed;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            steps = 0; ecount = 0; next_edge = 0;
            m_act = 0; m_pend = 0; m_done = 0; m_err = 0;
            m_lane = 0; m_left = 0; m_speed = 0;
            #1;
            chk("rst_valid", spawn_valid, 0);
            chk("rst_lane", spawn_lane, 0);
            chk("rst_left", notes_left, 0);
            chk("rst_speed", speed, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", level_err, 0);
         end else begin
            int lane_now;
            lane_now = int'(seq[steps % 16384][1:0]);
            steps++;
            ecount++;
            if (m_done) begin
               if (!level_valid) begin m_done = 0; m_speed = 0; end
            end else if (m_act) begin
               if (!level_valid) begin
                  m_act = 0; m_pend = 0; m_left = 0; m_speed = 0;
               end else if (m_pend) begin
                  if (spawn_ready) begin
                     m_pend = 0;
                     m_left--;
                     if (m_left == 0) begin m_act = 0; m_done = 1; end
                     else next_edge = ecount + BASE / m_speed;
                  end
               end else if (ecount == next_edge) begin
                  m_pend = 1;
                  m_lane = lane_now;
               end
            end else if (level_valid) begin
               if ($countones(level) == 1) begin
                  m_act = 1; m_err = 0;
                  m_speed = int'(level);
                  m_left = (level == 3'b001) ? 8 : (level == 3'b010) ? 12 : 16;
                  next_edge = ecount + BASE / m_speed;
               end else m_err = 1;
            end
            #1;
            chk("valid", spawn_valid, int'(m_pend));
            if (m_pend) chk("lane", spawn_lane, m_lane);
            chk("left", notes_left, m_left);
            chk("speed", speed, m_speed);
            chk("busy", busy, int'(m_act));
            chk("done", done, int'(m_done));
            chk("err", level_err, int'(m_err));
         end
      end
   end

   // mode: 100 = ready tied high, 0..99 = random ready percent, -1 = stall spawn #3
   task automatic round(input logic [2:0] lvl, input int mode, input int n_exp);
      int hs, nsp, latch, last, stall, lane3, cyc;
      bit prev, fin;
      hs = 0; nsp = 0; last = 0; stall = 0; lane3 = 0; prev = 0; fin = 0;
      @(negedge clk);
      level = lvl;
      level_valid = 1'b1;
      spawn_ready = (mode == 100);
      latch = ecount + 1;
      for (cyc = 0; cyc < 20000 && !fin; cyc++) begin
         @(negedge clk);
         if (done) begin
            fin = 1;
         end else begin
            if (spawn_valid && !prev) begin
               nsp++;
               if (nsp == 1) chk("first_gap", ecount - latch, BASE / int'(lvl));
               else if (mode == 100) chk("gap", ecount - last, BASE / int'(lvl) + 1);
               if (nsp == 3) lane3 = spawn_lane;
               last = ecount;
            end
            prev = spawn_valid;
            if (mode == -1 && nsp == 3 && spawn_valid && stall < 10) begin
               spawn_ready = 1'b0;
               stall++;
               chk("stall_lane", spawn_lane, lane3);
               chk("stall_left", notes_left, 10);
            end else if (mode == -1 && nsp == 4 && spawn_valid && stall == 10) begin
               chk("post_stall_gap", ecount - (last - 0), 0);
               chk("stall_gap", ecount - (latch + 3 * (BASE / 2 + 1) + 10 - 1), BASE / 2 + 1);
               stall++;
               spawn_ready = 1'b1;
            end else begin
               spawn_ready = (mode < 0) ? 1'b1 : (mode == 100) ? 1'b1 : ($urandom_range(0, 99) < mode);
            end
            hs += int'(spawn_valid && spawn_ready);
         end
      end
      chk("timeout", int'(fin), 1);
      chk("spawns", hs, n_exp);
      chk("left_end", notes_left, 0);
      level_valid = 1'b0;
      @(negedge clk);
      chk("done_clr", done, 0);
      chk("speed_clr", speed, 0);
   endtask

   initial begin
      rst = 1'b0; level = 3'b000; level_valid = 1'b0; spawn_ready = 1'b0;
      #1 rst = 1'b1;
      #11 rst = 1'b0;
      round(3'b001, 100, 8);
      round(3'b100, 100, 16);
      round(3'b010, -1, 12);
      @(negedge clk);
      level = 3'b011;
      level_valid = 1'b1;
      repeat (5) @(negedge clk);
      chk("illegal_err", level_err, 1);
      chk("illegal_busy", busy, 0);
      level_valid = 1'b0;
      @(negedge clk);
      round(3'b001, 50, 8);
      chk("err_cleared", level_err, 0);
      // abort while a spawn is pending, with ready on the same edge
      @(negedge clk);
      level = 3'b100; level_valid = 1'b1; spawn_ready = 1'b0;
      for (int i = 0; i < 100 && !spawn_valid; i++) @(negedge clk);
      chk("abort_pending", spawn_valid, 1);
      spawn_ready = 1'b1;
      level_valid = 1'b0;
      @(negedge clk);
      chk("abort_left", notes_left, 0);
      chk("abort_valid", spawn_valid, 0);
      chk("abort_busy", busy, 0);
      // asynchronous reset in the middle of a run
      level = 3'b001; level_valid = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrun_busy", busy, 1);
      #2 rst = 1'b1;
      #1 chk("async_left", notes_left, 0);
      chk("async_speed", speed, 0);
      #1 rst = 1'b0;
      level_valid = 1'b0;
      @(negedge clk);
      round(3'b001, 100, 8);
      // random traffic: levels, ready and restarts all randomized
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         spawn_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) == 0) level_valid = ~level_valid;
         if ($urandom_range(0, 29) == 0) level = 3'($urandom_range(0, 7));
      end
      level_valid = 1'b0;
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
